// File: rtl/ula_serial_ctrl.sv
// rtl/ula_serial_ctrl.sv - nibble-serial sequencer around one external ula_74181 slice
// Operands are presented to the slice LSB nibble first, with carry rippled through carry_q.
module ula_serial_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic [3:0]             op_s,
  input  logic                   op_m,
  input  logic                   op_cin,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_cin,
  input  logic [3:0]             alu_f,
  input  logic                   alu_cout,
  input  logic                   alu_aeqb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   res_f,
  output logic                   res_cout,
  output logic                   res_aeqb
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  f_q, f_d;
  logic [3:0]    s_q, s_d;
  logic          m_q, m_d;
  logic          carry_q, carry_d;
  logic          eq_q, eq_d;
  logic [W-1:0]  res_f_q, res_f_d;
  logic          res_cout_q, res_cout_d;
  logic          res_aeqb_q, res_aeqb_d;

  logic [3:0]    a_nib, b_nib;
  logic [W-1:0]  f_merge;
  logic          run;

  // Nibble select and the working result with the current slice output merged in.
  always_comb begin
    a_nib   = '0;
    b_nib   = '0;
    f_merge = f_q;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx_q == IW'(k)) begin
        a_nib              = a_q[4*k +: 4];
        b_nib              = b_q[4*k +: 4];
        f_merge[4*k +: 4]  = alu_f;
      end
    end
  end

  assign run       = (state_q == ST_RUN);
  assign alu_a     = run ? a_nib : 4'h0;
  assign alu_b     = run ? b_nib : 4'h0;
  assign alu_s     = run ? s_q : 4'h0;
  assign alu_m     = run & m_q;
  assign alu_cin   = run & carry_q;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign res_f     = res_f_q;
  assign res_cout  = res_cout_q;
  assign res_aeqb  = res_aeqb_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    f_d        = f_q;
    s_d        = s_q;
    m_d        = m_q;
    carry_d    = carry_q;
    eq_d       = eq_q;
    res_f_d    = res_f_q;
    res_cout_d = res_cout_q;
    res_aeqb_d = res_aeqb_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          s_d     = op_s;
          m_d     = op_m;
          carry_d = op_cin;
          eq_d    = 1'b1;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        f_d     = f_merge;
        carry_d = alu_cout;
        eq_d    = eq_q & alu_aeqb;
        if (idx_q == IDX_LAST) begin
          // Result registers change only here, so res_* never show a partial result.
          idx_d      = '0;
          state_d    = ST_DONE;
          res_f_d    = f_merge;
          res_cout_d = alu_cout;
          res_aeqb_d = eq_q & alu_aeqb;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      f_q        <= '0;
      s_q        <= '0;
      m_q        <= 1'b0;
      carry_q    <= 1'b0;
      eq_q       <= 1'b0;
      res_f_q    <= '0;
      res_cout_q <= 1'b0;
      res_aeqb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      f_q        <= f_d;
      s_q        <= s_d;
      m_q        <= m_d;
      carry_q    <= carry_d;
      eq_q       <= eq_d;
      res_f_q    <= res_f_d;
      res_cout_q <= res_cout_d;
      res_aeqb_q <= res_aeqb_d;
    end
  end

endmodule

// File: tb/tb_ula_serial_ctrl.sv
// tb/tb_ula_serial_ctrl.sv - directed bench for ula_serial_ctrl (4- and 1-nibble instances)
// The slice is a behavioural 74181 with active-high data and carry.
module tb_ula_serial_ctrl;

  logic clk;
  logic rst;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] op_a, op_b, res_f;
  logic [3:0]  op_s, alu_a, alu_b, alu_s, alu_f;
  logic        op_m, op_cin, alu_m, alu_cin, alu_cout, alu_aeqb, res_cout, res_aeqb;

  logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
  logic [3:0]  d1_op_a, d1_op_b, d1_res_f;
  logic [3:0]  d1_op_s, d1_alu_a, d1_alu_b, d1_alu_s, d1_alu_f;
  logic        d1_op_m, d1_op_cin, d1_alu_m, d1_alu_cin, d1_alu_cout, d1_alu_aeqb;
  logic        d1_res_cout, d1_res_aeqb;

  int total = 0;
  int bad   = 0;

  function automatic logic [5:0] alu181(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] s, input logic m, input logic cin);
    logic [3:0] x, y, f;
    logic [4:0] sum;
    x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {4'b0, cin};
    f   = m ? ~(x ^ y) : sum[3:0];
    return {&f, sum[4], f};
  endfunction

  assign {alu_aeqb, alu_cout, alu_f}          = alu181(alu_a, alu_b, alu_s, alu_m, alu_cin);
  assign {d1_alu_aeqb, d1_alu_cout, d1_alu_f} = alu181(d1_alu_a, d1_alu_b, d1_alu_s, d1_alu_m, d1_alu_cin);

  ula_serial_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_aeqb(alu_aeqb),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_f(res_f), .res_cout(res_cout), .res_aeqb(res_aeqb)
  );

  ula_serial_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .op_a(d1_op_a), .op_b(d1_op_b), .op_s(d1_op_s), .op_m(d1_op_m), .op_cin(d1_op_cin),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_s(d1_alu_s), .alu_m(d1_alu_m), .alu_cin(d1_alu_cin),
    .alu_f(d1_alu_f), .alu_cout(d1_alu_cout), .alu_aeqb(d1_alu_aeqb),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .res_f(d1_res_f), .res_cout(d1_res_cout), .res_aeqb(d1_res_aeqb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input logic m, input logic cin,
                       input logic [15:0] ef, input logic ec, input logic ee, input logic full);
    int   cyc;
    logic prev;
    @(negedge clk);
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc  = 0;
    prev = cin;
    while (out_valid !== 1'b1 && cyc < 20) begin
      chk({tag, " cin_chain"}, alu_cin, prev);
      prev = alu_cout;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, 4);
    chk({tag, " res_f"}, res_f, ef);
    if (full) begin
      chk({tag, " res_cout"}, res_cout, ec);
      chk({tag, " res_aeqb"}, res_aeqb, ee);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid_drop"}, out_valid, 0);
    chk({tag, " in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    in_valid = 0; out_ready = 0; op_a = 0; op_b = 0; op_s = 0; op_m = 0; op_cin = 0;
    d1_in_valid = 0; d1_out_ready = 0; d1_op_a = 0; d1_op_b = 0; d1_op_s = 0; d1_op_m = 0; d1_op_cin = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst res_f", res_f, 0);
    chk("rst res_cout", res_cout, 0);
    chk("rst res_aeqb", res_aeqb, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_cin", alu_cin, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst in_ready", in_ready, 1);

    // Pass-through A in logic mode, also gives a nonzero result for the reset test.
    do_op("pass_a", 16'h1234, 16'hFFFF, 4'hF, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);

    // Reset during RUN with idx=2.
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'hABCD; op_b = 16'h0000; op_s = 4'hF; op_m = 1'b1; op_cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrun alu_a idx2", alu_a, 4'hB);
    rst = 1'b1;
    #1;
    chk("midrun out_valid", out_valid, 0);
    chk("midrun res_f", res_f, 0);
    chk("midrun alu_a", alu_a, 0);
    chk("midrun alu_b", alu_b, 0);
    chk("midrun alu_s", alu_s, 0);
    chk("midrun alu_m", alu_m, 0);
    chk("midrun alu_cin", alu_cin, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrun in_ready", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("midrun no_valid", out_valid, 0);

    do_op("not_a", 16'h00FF, 16'h0000, 4'h0, 1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0, 1'b0);
    do_op("eq_yes", 16'hA5A5, 16'hA5A5, 4'h9, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    chk("eq_yes aeqb", res_aeqb, 1);
    do_op("eq_no", 16'hA5A5, 16'hA5A4, 4'h9, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    chk("eq_no aeqb", res_aeqb, 0);

    do_op("add_c0", 16'h0FFF, 16'h0001, 4'h9, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    do_op("add_c1", 16'h0FFF, 16'h0001, 4'h9, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b1);
    do_op("add_wrap", 16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op("sub_eq", 16'h3C3C, 16'h3C3C, 4'h6, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1);

    // Hold DONE with out_ready low while in_valid keeps pushing a different command.
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222; op_s = 4'h9; op_m = 1'b0; op_cin = 1'b0;
    @(posedge clk); #1;
    op_a = 16'hFFFF; op_b = 16'hFFFF; op_s = 4'h0; op_cin = 1'b1;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stall latency", cyc, 4);
    for (int i = 0; i < 10; i++) begin
      chk("stall res_f", res_f, 16'h3333);
      chk("stall res_aeqb", res_aeqb, 0);
      chk("stall out_valid", out_valid, 1);
      chk("stall in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("stall release out_valid", out_valid, 0);
    chk("stall release in_ready", in_ready, 1);
    chk("stall release res_f kept", res_f, 16'h3333);
    @(posedge clk); #1;
    chk("stall no_accept", in_ready, 1);

    // Single-nibble instance.
    @(negedge clk);
    d1_in_valid = 1'b1; d1_op_a = 4'h5; d1_op_b = 4'h3; d1_op_s = 4'hF; d1_op_m = 1'b1; d1_op_cin = 1'b0;
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    chk("n1 run out_valid", d1_out_valid, 0);
    chk("n1 run alu_a", d1_alu_a, 4'h5);
    @(posedge clk); #1;
    chk("n1 out_valid", d1_out_valid, 1);
    chk("n1 res_f", d1_res_f, 4'h5);
    @(negedge clk);
    d1_out_ready = 1'b1;
    @(posedge clk); #1;
    d1_out_ready = 1'b0;
    chk("n1 release", d1_in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
